// File: rtl/line_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | line_mem_pkg : shared types and constants for the line_memory block      |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
package line_mem_pkg;

   localparam int ADDR_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   // Keeps zero-width vectors out of degenerate parameter corners.
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/line_mem_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | line_mem_port : one request channel (FSM, latency countdown, capture)    |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module line_mem_port
   import line_mem_pkg::*;
#(
   parameter int WORD_W     = 16,
   parameter int DEPTH      = 256,
   parameter int LINE_WORDS = 4,
   parameter int LATENCY    = 4
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                i_req,
   input  logic                                i_we,
   input  logic [ADDR_W-1:0]                   i_addr,
   input  logic [LINE_WORDS*WORD_W-1:0]        i_wdata,
   input  logic [LINE_WORDS-1:0]               i_wmask,
   output logic                                o_ack,
   output logic                                o_fire,
   output logic                                o_we,
   output logic [clog2_min1(DEPTH)-1:0]        o_base,
   output logic [LINE_WORDS*WORD_W-1:0]        o_wdata,
   output logic [LINE_WORDS-1:0]               o_wmask
);

   localparam int MEM_AW = clog2_min1(DEPTH);

   state_t                         r_state;
   state_t                         w_state_nxt;
   logic                           w_accept;
   logic                           w_cnt_zero;
   logic                           w_live;
   logic                           r_we;
   logic [ADDR_W-1:0]              r_addr;
   logic [LINE_WORDS*WORD_W-1:0]   r_wdata;
   logic [LINE_WORDS-1:0]          r_wmask;
   logic [ADDR_W-1:0]              w_addr;
   logic                           w_unused_addr;

   assign w_accept = (r_state == IDLE) && i_req;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (i_req) w_state_nxt = (LATENCY == 1) ? DONE : WAIT;
         WAIT:    if (w_cnt_zero) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wmask <= '0;
      end else if (w_accept) begin
         r_we    <= i_we;
         r_addr  <= i_addr;
         r_wdata <= i_wdata;
         r_wmask <= i_wmask;
      end
   end

   // DONE is entered on edge acceptance+LATENCY-1, so WAIT sees LATENCY-2..0.
   if (LATENCY > 1) begin : g_cnt
      localparam int CNT_W = $clog2(LATENCY);
      localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(LATENCY - 2);
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
         if (reset)                              r_cnt <= '0;
         else if (w_accept)                      r_cnt <= c_cnt_load;
         else if (r_state == WAIT && r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      end

      assign w_cnt_zero = (r_cnt == '0);
   end else begin : g_nocnt
      assign w_cnt_zero = 1'b1;
   end

   // Firing straight out of IDLE only happens with LATENCY=1; then the
   // memory operation must use the request as presented, not the capture.
   assign w_live        = (r_state == IDLE);
   assign w_addr        = w_live ? i_addr  : r_addr;
   assign o_we          = w_live ? i_we    : r_we;
   assign o_wdata       = w_live ? i_wdata : r_wdata;
   assign o_wmask       = w_live ? i_wmask : r_wmask;
   assign o_base        = w_addr[MEM_AW-1:0] & ~MEM_AW'(LINE_WORDS - 1);
   assign o_fire        = (w_state_nxt == DONE) && !reset;
   assign o_ack         = (r_state == DONE);
   assign w_unused_addr = ^w_addr;

endmodule
`default_nettype wire

// File: rtl/line_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | line_memory : dual-channel (I read-only, D read/write) line memory       |
// | Optional per-word write mask enabled by LINE_MEM_WMASK_EN               |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module line_memory
   import line_mem_pkg::*;
#(
   parameter int    WORD_W     = 16,
   parameter int    DEPTH      = 256,
   parameter int    LINE_WORDS = 4,
   parameter int    LATENCY    = 4,
   parameter string INIT_FILE  = ""
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          i_req,
   input  logic [ADDR_W-1:0]             i_addr,
   output logic                          i_ack,
   output logic [LINE_WORDS*WORD_W-1:0]  i_rdata,
   input  logic                          d_req,
   input  logic                          d_we,
   input  logic [ADDR_W-1:0]             d_addr,
   output logic                          d_ack,
   input  logic [LINE_WORDS*WORD_W-1:0]  d_wdata,
`ifdef LINE_MEM_WMASK_EN
   input  logic [LINE_WORDS-1:0]         d_wmask,
`endif
   output logic [LINE_WORDS*WORD_W-1:0]  d_rdata
);

   localparam int MEM_AW = clog2_min1(DEPTH);
   localparam int LINE_W = LINE_WORDS * WORD_W;

   logic [WORD_W-1:0]      r_mem [DEPTH];
   logic [LINE_W-1:0]      r_i_rdata;
   logic [LINE_W-1:0]      r_d_rdata;
   logic [LINE_W-1:0]      w_i_line;
   logic [LINE_W-1:0]      w_d_line;
   logic [LINE_WORDS-1:0]  w_d_wmask_in;

   logic                   w_i_fire;
   logic                   w_i_we;
   logic [MEM_AW-1:0]      w_i_base;
   logic [LINE_W-1:0]      w_i_wdata;
   logic [LINE_WORDS-1:0]  w_i_wmask;
   logic                   w_unused_i;

   logic                   w_d_fire;
   logic                   w_d_we;
   logic [MEM_AW-1:0]      w_d_base;
   logic [LINE_W-1:0]      w_d_wdata;
   logic [LINE_WORDS-1:0]  w_d_wmask;

`ifdef LINE_MEM_WMASK_EN
   assign w_d_wmask_in = d_wmask;
`else
   assign w_d_wmask_in = '1;
`endif

   line_mem_port #(
      .WORD_W(WORD_W), .DEPTH(DEPTH), .LINE_WORDS(LINE_WORDS), .LATENCY(LATENCY)
   ) u_iport (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_we(1'b0), .i_addr(i_addr), .i_wdata('0), .i_wmask('0),
      .o_ack(i_ack), .o_fire(w_i_fire), .o_we(w_i_we), .o_base(w_i_base),
      .o_wdata(w_i_wdata), .o_wmask(w_i_wmask)
   );

   line_mem_port #(
      .WORD_W(WORD_W), .DEPTH(DEPTH), .LINE_WORDS(LINE_WORDS), .LATENCY(LATENCY)
   ) u_dport (
      .clk(clk), .reset(reset),
      .i_req(d_req), .i_we(d_we), .i_addr(d_addr), .i_wdata(d_wdata),
      .i_wmask(w_d_wmask_in),
      .o_ack(d_ack), .o_fire(w_d_fire), .o_we(w_d_we), .o_base(w_d_base),
      .o_wdata(w_d_wdata), .o_wmask(w_d_wmask)
   );

   // The instruction channel never writes.
   assign w_unused_i = ^{w_i_we, w_i_wdata, w_i_wmask};

   always_comb begin
      w_i_line = '0;
      w_d_line = '0;
      for (int k = 0; k < LINE_WORDS; k++) begin
         w_i_line[k*WORD_W +: WORD_W] = r_mem[w_i_base | MEM_AW'(k)];
         w_d_line[k*WORD_W +: WORD_W] = r_mem[w_d_base | MEM_AW'(k)];
      end
   end

   // Non-blocking update gives read-first behaviour to a same-edge I read.
   always_ff @(posedge clk) begin
      if (w_d_fire && w_d_we) begin
         for (int k = 0; k < LINE_WORDS; k++) begin
            if (w_d_wmask[k])
               r_mem[w_d_base | MEM_AW'(k)] <= w_d_wdata[k*WORD_W +: WORD_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         if (w_i_fire)             r_i_rdata <= w_i_line;
         if (w_d_fire && !w_d_we)  r_d_rdata <= w_d_line;
      end
   end

   assign i_rdata = r_i_rdata;
   assign d_rdata = r_d_rdata;

endmodule
`default_nettype wire
